// File: rtl/line_sequencer_if.sv
// Signal bundle between line_sequencer and its surroundings: operator controls,
// the line_drawer handshake, and the endpoints/colour fed to the framebuffer path.
interface line_sequencer_if;
   // Handshake: draw_start is a one-cycle request that (re)launches line_drawer
   // using x0..y1 and pixel_color. draw_done is line_drawer's one-cycle
   // completion pulse. There is no back-pressure. Endpoints stay stable from
   // draw_start until the sequencer loads its next line.
   logic       enable;
   logic       clear_req;
   logic       draw_done;
   logic       draw_start;
   logic [9:0] x0;
   logic [8:0] y0;
   logic [9:0] x1;
   logic [8:0] y1;
   logic       pixel_color;
   logic [2:0] seg_index;
   logic       busy;
   logic [2:0] state_dbg;

   modport master (
      input  enable, clear_req, draw_done,
      output draw_start, x0, y0, x1, y1, pixel_color, seg_index, busy, state_dbg
   );

   modport slave (
      output enable, clear_req, draw_done,
      input  draw_start, x0, y0, x1, y1, pixel_color, seg_index, busy, state_dbg
   );
endinterface

// File: rtl/line_sequencer.sv
// Walks a fixed table of line segments for line_drawer, one start/done handshake
// per segment with a pausable hold between them, plus a column-by-column clear sweep.
module line_sequencer #(
   parameter int unsigned NUM_SEG      = 6,
   parameter int unsigned HOLD_CYCLES  = 25000000,
   parameter int unsigned DONE_TIMEOUT = 2048,
   parameter int unsigned SCREEN_W     = 640,
   parameter int unsigned SCREEN_H     = 480
) (
   input  logic             clk,
   input  logic             reset_n,
   line_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_DONE,
      HOLD,
      CLR_LOAD,
      CLR_START,
      CLR_WAIT
   } state_t;

   typedef struct packed {
      logic [9:0] x0;
      logic [8:0] y0;
      logic [9:0] x1;
      logic [8:0] y1;
   } seg_t;

   localparam logic [2:0]  SEG_LAST  = 3'(NUM_SEG - 1);
   localparam logic [24:0] HOLD_LAST = 25'(HOLD_CYCLES - 1);
   localparam logic [10:0] TMO_LAST  = 11'(DONE_TIMEOUT - 1);
   localparam logic [9:0]  COL_LAST  = 10'(SCREEN_W - 1);
   localparam logic [8:0]  ROW_LAST  = 9'(SCREEN_H - 1);

   function automatic seg_t seg_lookup(input logic [2:0] idx);
      seg_t s;
      case (idx)
         3'd0:    s = '{x0: 10'd240, y0: 9'd340, x1: 10'd240, y1: 9'd240};
         3'd1:    s = '{x0: 10'd340, y0: 9'd340, x1: 10'd240, y1: 9'd180};
         3'd2:    s = '{x0: 10'd340, y0: 9'd240, x1: 10'd180, y1: 9'd180};
         3'd3:    s = '{x0: 10'd240, y0: 9'd240, x1: 10'd180, y1: 9'd240};
         3'd4:    s = '{x0: 10'd240, y0: 9'd290, x1: 10'd240, y1: 9'd350};
         3'd5:    s = '{x0: 10'd290, y0: 9'd340, x1: 10'd350, y1: 9'd240};
         default: s = '0;
      endcase
      return s;
   endfunction

   state_t      state_q, state_d;
   logic [9:0]  x0_q, x0_d;
   logic [8:0]  y0_q, y0_d;
   logic [9:0]  x1_q, x1_d;
   logic [8:0]  y1_q, y1_d;
   logic [2:0]  seg_q, seg_d;
   logic [24:0] hold_q, hold_d;
   logic [9:0]  col_q, col_d;
   logic [10:0] tmo_q, tmo_d;
   logic        pix_q, pix_d;

   seg_t        cur_seg;
   logic        in_clr;
   logic        wait_over;

   assign cur_seg   = seg_lookup(seg_q);
   assign in_clr    = (state_q == CLR_LOAD) || (state_q == CLR_START) || (state_q == CLR_WAIT);
   assign wait_over = bus.draw_done || (tmo_q == TMO_LAST);

   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      seg_d   = seg_q;
      hold_d  = hold_q;
      col_d   = col_q;
      tmo_d   = tmo_q;
      pix_d   = pix_q;

      // A clear request preempts every animation state, including a pending load.
      if (bus.clear_req && !in_clr) begin
         state_d = CLR_LOAD;
         col_d   = '0;
         seg_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.enable) state_d = LOAD;
            end
            LOAD: begin
               x0_d    = cur_seg.x0;
               y0_d    = cur_seg.y0;
               x1_d    = cur_seg.x1;
               y1_d    = cur_seg.y1;
               pix_d   = 1'b1;
               state_d = START;
            end
            START: begin
               tmo_d   = '0;
               state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
               if (wait_over) begin
                  hold_d  = '0;
                  state_d = HOLD;
               end else begin
                  tmo_d = tmo_q + 11'd1;
               end
            end
            HOLD: begin
               // With enable low the hold count freezes, stretching the pause.
               if (bus.enable) begin
                  if (hold_q == HOLD_LAST) begin
                     seg_d   = (seg_q == SEG_LAST) ? 3'd0 : seg_q + 3'd1;
                     state_d = LOAD;
                  end else begin
                     hold_d = hold_q + 25'd1;
                  end
               end
            end
            CLR_LOAD: begin
               x0_d    = col_q;
               x1_d    = col_q;
               y0_d    = '0;
               y1_d    = ROW_LAST;
               pix_d   = 1'b0;
               state_d = CLR_START;
            end
            CLR_START: begin
               tmo_d   = '0;
               state_d = CLR_WAIT;
            end
            CLR_WAIT: begin
               if (wait_over) begin
                  if (col_q == COL_LAST) begin
                     pix_d   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     col_d   = col_q + 10'd1;
                     state_d = CLR_LOAD;
                  end
               end else begin
                  tmo_d = tmo_q + 11'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         seg_q   <= '0;
         hold_q  <= '0;
         col_q   <= '0;
         tmo_q   <= '0;
         pix_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         seg_q   <= seg_d;
         hold_q  <= hold_d;
         col_q   <= col_d;
         tmo_q   <= tmo_d;
         pix_q   <= pix_d;
      end
   end

   // draw_start is decoded from the state register, so it is a clean one-cycle
   // pulse and cannot fire while reset holds the FSM in IDLE.
   assign bus.draw_start  = (state_q == START) || (state_q == CLR_START);
   assign bus.busy        = (state_q != IDLE);
   assign bus.x0          = x0_q;
   assign bus.y0          = y0_q;
   assign bus.x1          = x1_q;
   assign bus.y1          = y1_q;
   assign bus.pixel_color = pix_q;
   assign bus.seg_index   = seg_q;
   assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_line_sequencer.sv
// Self-checking bench for line_sequencer: table of randomized segment responses,
// clear sweeps, pause and asynchronous reset sequences against a timing/endpoint model.
module tb_line_sequencer;

   localparam int NSEG = 6;
   localparam int HOLD = 8;
   localparam int TMO  = 16;
   localparam int SW   = 4;
   localparam int SH   = 480;
   localparam int EW   = 42;
   localparam int NVEC = 9;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   line_sequencer_if dut_if ();

   line_sequencer #(
      .NUM_SEG      (NSEG),
      .HOLD_CYCLES  (HOLD),
      .DONE_TIMEOUT (TMO),
      .SCREEN_W     (SW),
      .SCREEN_H     (SH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (dut_if.master)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];

   int tab_x0 [NSEG] = '{240, 340, 340, 240, 240, 290};
   int tab_y0 [NSEG] = '{340, 340, 240, 240, 290, 340};
   int tab_x1 [NSEG] = '{240, 240, 180, 180, 240, 350};
   int tab_y1 [NSEG] = '{240, 180, 180, 240, 350, 240};

   typedef struct {
      int            w;
      int            pause;
      bit            stray;
      logic [EW-1:0] exp_pkt;
      int            exp_gap;
   } vec_t;

   vec_t vecs [NVEC];

   // ---------------- reference model ----------------
   function automatic logic [EW-1:0] pack_exp(input int seg, input int x0, input int y0,
                                              input int x1, input int y1, input bit pc);
      return {3'(seg), 10'(x0), 9'(y0), 10'(x1), 9'(y1), pc};
   endfunction

   function automatic logic [EW-1:0] model_seg(input int seg);
      return pack_exp(seg, tab_x0[seg], tab_y0[seg], tab_x1[seg], tab_y1[seg], 1'b1);
   endfunction

   function automatic logic [EW-1:0] model_clr(input int col);
      return pack_exp(0, col, 0, col, SH - 1, 1'b0);
   endfunction

   function automatic int wait_len(input int w);
      return (w < TMO) ? w : TMO;
   endfunction

   // Start-to-start distance for a drawn segment: wait, hold, one load, then start.
   function automatic int model_gap(input int w, input int pause);
      return wait_len(w) + HOLD + 2 + pause;
   endfunction

   function automatic logic [EW-1:0] dut_pkt();
      return {dut_if.seg_index, dut_if.x0, dut_if.y0, dut_if.x1, dut_if.y1, dut_if.pixel_color};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic observe(input string name);
      logic [EW-1:0] exp;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s actual=no_expectation required=queued_line", name);
      end else begin
         exp = exp_q.pop_front();
         check(name, 64'(dut_pkt()), 64'(exp));
      end
      check({name, "_start"}, 64'(dut_if.draw_start), 64'd1);
      check({name, "_busy"}, 64'(dut_if.busy), 64'd1);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_x0"}, 64'(dut_if.x0), 64'd0);
      check({tag, "_y0"}, 64'(dut_if.y0), 64'd0);
      check({tag, "_x1"}, 64'(dut_if.x1), 64'd0);
      check({tag, "_y1"}, 64'(dut_if.y1), 64'd0);
      check({tag, "_seg"}, 64'(dut_if.seg_index), 64'd0);
      check({tag, "_start"}, 64'(dut_if.draw_start), 64'd0);
      check({tag, "_pix"}, 64'(dut_if.pixel_color), 64'd1);
      check({tag, "_busy"}, 64'(dut_if.busy), 64'd0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in a start cycle: answers with draw_done in wait cycle w (none if w > TMO),
   // optionally pokes clear_req in the first wait cycle, and ends one cycle past the wait.
   task automatic respond(input int w, input bit poke, inout int el);
      int n;
      n = wait_len(w);
      for (int i = 1; i <= n; i++) begin
         tick();
         el++;
         if (i == 1) check("start_pulse_width", 64'(dut_if.draw_start), 64'd0);
         dut_if.clear_req = poke && (i == 1);
         dut_if.draw_done = (i == w);
      end
      tick();
      el++;
      dut_if.draw_done = 1'b0;
      dut_if.clear_req = 1'b0;
   endtask

   // Bounded wait for draw_start; optional stray done in the first cycle and an
   // enable-low window of pause cycles starting two cycles in.
   task automatic wait_start(input int pause, input bit stray, inout int el,
                             output bit got, input int budget);
      got = 1'b0;
      for (int r = 0; r < budget; r++) begin
         if (dut_if.draw_start) begin
            got = 1'b1;
            break;
         end
         dut_if.draw_done = stray && (r == 0);
         if (pause > 0) dut_if.enable = !(r >= 2 && r < 2 + pause);
         tick();
         el++;
      end
      dut_if.draw_done = 1'b0;
   endtask

   // Starts in the cycle after an accepted clear request.
   task automatic sweep(input bit poke, input bit end_en);
      int el;
      int w;
      bit got;
      el = 0;
      wait_start(0, 1'b0, el, got, 8);
      check("clr_first_seen", 64'(got), 64'd1);
      check("clr_first_latency", 64'(el), 64'd1);
      for (int col = 0; col < SW; col++) begin
         exp_q.push_back(model_clr(col));
         observe("clr_line");
         w = $urandom_range(1, 20);
         if (col == SW - 1) dut_if.enable = end_en;
         el = 0;
         respond(w, poke && (col == 1), el);
         if (col < SW - 1) begin
            wait_start(0, 1'b0, el, got, 40);
            check("clr_next_seen", 64'(got), 64'd1);
            check("clr_gap", 64'(el), 64'(wait_len(w) + 2));
         end
      end
      check("clr_end_busy", 64'(dut_if.busy), 64'd0);
      check("clr_end_pix", 64'(dut_if.pixel_color), 64'd1);
      check("clr_end_seg", 64'(dut_if.seg_index), 64'd0);
      check("clr_end_start", 64'(dut_if.draw_start), 64'd0);
      if (end_en) begin
         el = 0;
         wait_start(0, 1'b0, el, got, 8);
         check("resume_seen", 64'(got), 64'd1);
         check("resume_latency", 64'(el), 64'd2);
         exp_q.push_back(model_seg(0));
         observe("resume_seg0");
      end else begin
         repeat (5) tick();
         check("idle_stays_busy", 64'(dut_if.busy), 64'd0);
         check("idle_stays_start", 64'(dut_if.draw_start), 64'd0);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      int  el;
      bit  got;

      dut_if.enable    = 1'b0;
      dut_if.clear_req = 1'b0;
      dut_if.draw_done = 1'b0;

      for (int k = 0; k < NVEC; k++) begin
         vecs[k].w       = (k == 0) ? 5 : (k == 5) ? 99 : int'($urandom_range(1, 12));
         vecs[k].pause   = (k == 6) ? 10 : 0;
         vecs[k].stray   = (k == 7);
         vecs[k].exp_pkt = model_seg((k + 1) % NSEG);
         vecs[k].exp_gap = model_gap(vecs[k].w, vecs[k].pause);
      end

      repeat (3) tick();
      check_reset("reset");

      reset_n       = 1'b1;
      dut_if.enable = 1'b1;
      tick();
      check("latency_cycle1_start", 64'(dut_if.draw_start), 64'd0);
      check("latency_cycle1_busy", 64'(dut_if.busy), 64'd1);
      tick();
      exp_q.push_back(model_seg(0));
      observe("first_seg0");

      for (int k = 0; k < NVEC; k++) begin
         el = 0;
         respond(vecs[k].w, 1'b0, el);
         wait_start(vecs[k].pause, vecs[k].stray, el, got, 80);
         check("seg_seen", 64'(got), 64'd1);
         check("seg_gap", 64'(el), 64'(vecs[k].exp_gap));
         exp_q.push_back(vecs[k].exp_pkt);
         observe("seg_line");
      end

      // Clear during the hold after segment 3; a clear poke mid-sweep must be ignored.
      el = 0;
      respond(3, 1'b0, el);
      tick();
      tick();
      dut_if.clear_req = 1'b1;
      tick();
      dut_if.clear_req = 1'b0;
      sweep(1'b1, 1'b0);

      // Clear wins over enable when both arrive in IDLE.
      dut_if.enable    = 1'b1;
      dut_if.clear_req = 1'b1;
      tick();
      dut_if.clear_req = 1'b0;
      sweep(1'b0, 1'b1);

      // Asynchronous reset in the middle of a wait cycle.
      tick();
      tick();
      #3;
      reset_n = 1'b0;
      #1;
      check_reset("async_reset");
      for (int i = 0; i < 4; i++) begin
         tick();
         check("in_reset_start", 64'(dut_if.draw_start), 64'd0);
         check("in_reset_busy", 64'(dut_if.busy), 64'd0);
      end
      reset_n = 1'b1;
      tick();
      check("post_reset_cycle1_start", 64'(dut_if.draw_start), 64'd0);
      tick();
      exp_q.push_back(model_seg(0));
      observe("post_reset_seg0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
